// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sharing one combinational ALU: round-robin grant, operand hold, registered response.
// Optional grant counters enabled by defining ALU_SHARE_ARBITER_PERF_EN.
//
// state  | meaning
// S_IDLE | waiting for a request; ReqReady offered to the granted requester
// S_EXEC | operands held on the ALU; down-counter runs to the capture cycle
// S_RESP | captured result presented until the consumer accepts it
module alu_share_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ReqValid,
  output logic [1:0]  ReqReady,
  input  logic [31:0] ReqA0,
  input  logic [31:0] ReqB0,
  input  logic [31:0] ReqA1,
  input  logic [31:0] ReqB1,
  input  logic [3:0]  ReqOp0,
  input  logic [3:0]  ReqOp1,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic [3:0]  AluOp,
  input  logic [31:0] AluRes,
  output logic        RspValid,
  output logic        RspId,
  output logic [31:0] RspData,
  input  logic        RspReady
`ifdef ALU_SHARE_ARBITER_PERF_EN
  ,
  output logic [15:0] GrantCnt0,
  output logic [15:0] GrantCnt1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t      state, state_nxt;
  logic        rr_ptr;
  logic [3:0]  cnt;
  logic [1:0]  grant;
  logic        xfer;
  logic        rsp_hs;

  // Grant is gated by rst so no requester sees ReqReady while reset is held.
  always_comb begin
    grant = 2'b00;
    if (state == S_IDLE && !rst) begin
      case (ReqValid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign ReqReady = grant;
  assign xfer     = |grant;
  assign RspValid = (state == S_RESP) && !rst;
  assign rsp_hs   = RspValid && RspReady;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (xfer) state_nxt = S_EXEC;
      S_EXEC:  if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  if (rsp_hs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rr_ptr  <= 1'b0;
      cnt     <= 4'd0;
      AluA    <= 32'd0;
      AluB    <= 32'd0;
      AluOp   <= 4'd0;
      RspId   <= 1'b0;
      RspData <= 32'd0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        AluA  <= grant[1] ? ReqA1  : ReqA0;
        AluB  <= grant[1] ? ReqB1  : ReqB0;
        AluOp <= grant[1] ? ReqOp1 : ReqOp0;
        RspId <= grant[1];
        cnt   <= CNT_LOAD;
      end
      if (state == S_EXEC) begin
        if (cnt == 4'd0) RspData <= AluRes;
        else             cnt <= cnt - 4'd1;
      end
      // Next tie goes to whoever was not just served.
      if (rsp_hs) rr_ptr <= ~RspId;
    end
  end

`ifdef ALU_SHARE_ARBITER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      GrantCnt0 <= 16'd0;
      GrantCnt1 <= 16'd0;
    end else begin
      if (grant[0] && GrantCnt0 != 16'hFFFF) GrantCnt0 <= GrantCnt0 + 16'd1;
      if (grant[1] && GrantCnt1 != 16'hFFFF) GrantCnt1 <= GrantCnt1 + 16'd1;
    end
  end
`endif

endmodule
